// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage: run-control states,
// IF/ID register layout and the per-cycle fetch action decode.
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_LOAD,
        IFID_BUBBLE
    } ifid_op_e;

    // One decoded action per cycle; the RUN-state priority chain maps onto these.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_START,
        ACT_HALT,
        ACT_REDIRECT,
        ACT_SQUASH,
        ACT_FLUSH,
        ACT_STALL,
        ACT_FETCH
    } fetch_act_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    localparam ifid_t IFID_EMPTY = '{instr: NOP_INSTR, pc4: 32'h0000_0000, valid: 1'b0};

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
module fetch_ifid_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  ifid_op_e    op_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output ifid_t       ifid_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ifid_d = ifid_q;
        unique case (op_i)
            IFID_LOAD:   ifid_d = '{instr: instr_i, pc4: pc4_i, valid: 1'b1};
            IFID_BUBBLE: ifid_d = IFID_EMPTY;
            default:     ifid_d = ifid_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q <= IFID_EMPTY;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_o = ifid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the instruction memory address,
// fills IF/ID and runs the IDLE/RUN/HALTED run-control machine.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_03FC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        halt,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [1:0]  state,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  count_q, count_d;
    fetch_act_e   act;
    ifid_op_e     ifid_op;
    ifid_t        ifid;

    logic [31:0]  pc_plus4;
    logic         at_limit;

    assign pc_plus4 = pc_q + PC_STEP;
    assign at_limit = (pc_q == PC_LIMIT);

    // Priority decode: halt > redirect > flush&stall > flush > stall > fetch.
    always_comb begin
        act = ACT_NONE;
        unique case (state_q)
            FS_IDLE: begin
                if (start) act = ACT_START;
            end
            FS_RUN: begin
                if (halt)                act = ACT_HALT;
                else if (redirect)       act = ACT_REDIRECT;
                else if (flush && stall) act = ACT_SQUASH;
                else if (flush)          act = ACT_FLUSH;
                else if (stall)          act = ACT_STALL;
                else                     act = ACT_FETCH;
            end
            default: act = ACT_NONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        ifid_op = IFID_BUBBLE;
        unique case (act)
            ACT_START:    state_d = FS_RUN;
            ACT_HALT:     state_d = FS_HALTED;
            ACT_REDIRECT: pc_d = word_align(redirect_pc);
            ACT_SQUASH:   pc_d = pc_q;
            ACT_FLUSH: begin
                // At the last word the flushed fetch is retried rather than wrapping.
                if (!at_limit) pc_d = pc_plus4;
            end
            ACT_STALL:    ifid_op = IFID_HOLD;
            ACT_FETCH: begin
                ifid_op = IFID_LOAD;
                if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
                if (at_limit) state_d = FS_HALTED;
                else          pc_d    = pc_plus4;
            end
            default: ifid_op = IFID_BUBBLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FS_IDLE;
            pc_q    <= word_align(RESET_PC);
            count_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    fetch_ifid_reg u_ifid (
        .clk     (CLK),
        .rst     (RST),
        .op_i    (ifid_op),
        .instr_i (imem_instr),
        .pc4_i   (pc_plus4),
        .ifid_o  (ifid)
    );

    assign imem_addr   = pc_q;
    assign state       = state_q;
    assign fetch_count = count_q;
    assign ifid_instr  = ifid.instr;
    assign ifid_pc4    = ifid.pc4;
    assign ifid_valid  = ifid.valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed test-plan sequence plus random
// episodes, checked against a behavioural fetch model.
module tb_fetch_ctrl;

    localparam logic [31:0] TB_LIMIT = 32'h0000_0020;

    logic        CLK;
    logic        RST;
    logic        start, halt, stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] ifid_instr, ifid_pc4;
    logic        ifid_valid;
    logic [1:0]  state;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] st;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] valid;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int          m_st;
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    fetch_ctrl #(.RESET_PC(32'h0), .PC_LIMIT(TB_LIMIT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .halt        (halt),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid),
        .state       (state),
        .fetch_count (fetch_count)
    );

    assign imem_instr = (imem_addr < 32'h400) ? mem[imem_addr[9:2]] : 32'h0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    // One rising edge of the fetch stage, straight from the behavioural rules.
    task automatic model_step();
        if (m_st == 0) begin
            model_bubble();
            if (start) m_st = 1;
        end else if (m_st == 1) begin
            if (halt) begin
                m_st = 2; model_bubble();
            end else if (redirect) begin
                m_pc = (redirect_pc / 4) * 4; model_bubble();
            end else if (flush && stall) begin
                model_bubble();
            end else if (flush) begin
                model_bubble();
                if (m_pc != TB_LIMIT) m_pc = m_pc + 4;
            end else if (stall) begin
                // everything held
            end else begin
                m_instr = mem[m_pc / 4];
                m_pc4   = m_pc + 4;
                m_valid = 1'b1;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_pc == TB_LIMIT) m_st = 2;
                else                  m_pc = m_pc + 4;
            end
        end else begin
            model_bubble();
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic s, input logic h, input logic st, input logic f,
                        input logic r, input logic [31:0] rpc);
        exp_t e;
        start = s; halt = h; stall = st; flush = f; redirect = r; redirect_pc = rpc;
        @(posedge CLK);
        model_step();
        e.st = m_st; e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
        e.valid = {31'b0, m_valid}; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic fetch_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, {30'b0, state}, 32'h0);
        check({tag, "_imem_addr"}, imem_addr, 32'h0);
        check({tag, "_ifid_instr"}, ifid_instr, 32'h0);
        check({tag, "_ifid_pc4"}, ifid_pc4, 32'h0);
        check({tag, "_ifid_valid"}, {31'b0, ifid_valid}, 32'h0);
        check({tag, "_fetch_count"}, fetch_count, 32'h0);
    endtask

    // Asserts RST between edges and checks the asynchronous effect before any edge.
    task automatic do_reset(input string tag);
        start = 0; halt = 0; stall = 0; flush = 0; redirect = 0; redirect_pc = 32'h0;
        #2 RST = 1'b1;
        #1 check_reset_outputs(tag);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Monitor: compares DUT outputs against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_state", {30'b0, state}, e.st);
                check("sb_imem_addr", imem_addr, e.pc);
                check("sb_ifid_instr", ifid_instr, e.instr);
                check("sb_ifid_pc4", ifid_pc4, e.pc4);
                check("sb_ifid_valid", {31'b0, ifid_valid}, e.valid);
                check("sb_fetch_count", fetch_count, e.cnt);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h8C220004; mem[1] = 32'h00441820; mem[2] = 32'hAC230008;
        mem[3] = 32'h10600002; mem[4] = 32'h00631820;
        model_reset();
        RST = 1'b1;
        start = 0; halt = 0; stall = 0; flush = 0; redirect = 0; redirect_pc = 32'h0;
        #3 check_reset_outputs("por");
        @(negedge CLK);
        RST = 1'b0;

        // Basic run and stall
        step(1, 0, 0, 0, 0, 32'h0);
        check("start_state", {30'b0, state}, 32'd1);
        check("start_no_capture", {31'b0, ifid_valid}, 32'd0);
        fetch_n(2);
        check("run_instr1", ifid_instr, 32'h00441820);
        step(0, 0, 1, 0, 0, 32'h0);
        step(0, 0, 1, 0, 0, 32'h0);
        check("stall_instr", ifid_instr, 32'h00441820);
        check("stall_addr", imem_addr, 32'h8);
        check("stall_count", fetch_count, 32'd2);
        fetch_n(1);
        check("post_stall_instr", ifid_instr, 32'hAC230008);
        check("post_stall_pc4", ifid_pc4, 32'hC);
        check("post_stall_count", fetch_count, 32'd3);
        fetch_n(1);
        check("pre_redir_addr", imem_addr, 32'h10);

        // Redirect to an unaligned target
        step(0, 0, 0, 0, 1, 32'h15);
        check("redir_bubble", {31'b0, ifid_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h14);
        fetch_n(1);
        check("redir_target_instr", ifid_instr, 32'h0);
        check("redir_target_pc4", ifid_pc4, 32'h18);

        // Simultaneous events
        step(0, 0, 1, 1, 1, 32'h4);
        check("rsf_addr", imem_addr, 32'h4);
        step(0, 0, 1, 1, 0, 32'h0);
        check("fs_addr_held", imem_addr, 32'h4);
        check("fs_bubble", {31'b0, ifid_valid}, 32'd0);
        step(0, 0, 0, 1, 0, 32'h0);
        check("flush_addr", imem_addr, 32'h8);
        fetch_n(1);
        step(0, 1, 0, 0, 1, 32'h18);
        check("halt_redir_state", {30'b0, state}, 32'd2);
        check("halt_redir_addr", imem_addr, 32'hC);
        step(1, 0, 0, 0, 0, 32'h0);
        fetch_n(1);
        check("halted_sticky", {30'b0, state}, 32'd2);
        do_reset("rst_after_halt");

        // Limit: run to TB_LIMIT, flush there retries, then capture halts
        step(1, 0, 0, 0, 0, 32'h0);
        fetch_n(8);
        check("limit_addr", imem_addr, TB_LIMIT);
        step(0, 0, 0, 1, 0, 32'h0);
        check("limit_flush_hold", imem_addr, TB_LIMIT);
        fetch_n(1);
        check("limit_state", {30'b0, state}, 32'd2);
        check("limit_pc4", ifid_pc4, TB_LIMIT + 32'd4);
        step(1, 0, 0, 0, 0, 32'h0);
        check("limit_start_ignored", {30'b0, state}, 32'd2);
        check("limit_addr_frozen", imem_addr, TB_LIMIT);
        do_reset("rst_after_limit");

        // Reset mid-run while IF/ID holds a real instruction
        step(1, 0, 0, 0, 0, 32'h0);
        fetch_n(2);
        check("midrun_valid", {31'b0, ifid_valid}, 32'd1);
        do_reset("rst_midrun");

        // Random episodes over a randomised program image
        for (int i = 5; i < 256; i++) mem[i] = $urandom;
        for (int ep = 0; ep < 25; ep++) begin
            for (int c = 0; c < 50; c++) begin
                step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3,
                     $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 12,
                     $urandom_range(0, 99) < 10, $urandom_range(0, TB_LIMIT + 3));
            end
            do_reset("rst_random");
        end

        repeat (2) @(negedge CLK);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
